wb_trace_collector: RTL

//  Receiving end of the core's retirement/writeback trace (wb_e/wb_a/wb_d, ins_done, done).

---
 rtl/trace_pkg.sv | 18 +
 rtl/trace_fifo.sv | 51 +++++
 rtl/wb_trace_collector.sv | 120 ++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared record layout, sizes and state encodings for the writeback trace collector
package trace_pkg;
   localparam int REC_W     = 56;
   localparam int REC_BYTES = 7;

   // Record is sent MSB first: retire_idx, is_final, ovf_gap, wb_e, wb_a, wb_d
   typedef struct packed {
      logic [15:0] retire_idx;
      logic        is_final;
      logic        ovf_gap;
      logic        wb_e;
      logic [4:0]  wb_a;
      logic [31:0] wb_d;
   } trace_rec_s;

   typedef enum logic {CAPTURE, STOPPED} trc_state_e;
   typedef enum logic {SER_IDLE, SER_SEND} ser_state_e;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous record FIFO with registered occupancy count
//  clk, reset        clock, asynchronous active-high reset
//  push_i / wdata_i  write a record (ignored when full)
//  pop_i  / rdata_o  consume the head record (ignored when empty); rdata_o shows the head
//  full_o, empty_o   occupancy flags
//  count_o           records held (0..DEPTH)
module trace_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 56
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign full_o  = cnt_q[AW];
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end
endmodule

// File: rtl/wb_trace_collector.sv
// wb_trace_collector: captures retirement trace into 56-bit records and streams them out byte-serially
//  clk, reset            clock, asynchronous active-high reset
//  trace_en              capture enable (retire counter runs regardless)
//  ins_done, done        retirement / final retirement strobes
//  wb_e, wb_a, wb_d      writeback enable, destination register, data
//  tx_valid/tx_ready     byte link handshake, tx_data the byte (MSB of record first)
//  overflow              sticky record-dropped flag
//  drop_count            saturating dropped-record count
//  drained               stopped after done with FIFO and serializer empty
//  Build option TRACE_FILTER_EN: skip retirements that do not write a non-zero register.
module wb_trace_collector
   import trace_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             trace_en,
   input  logic             ins_done,
   input  logic             done,
   input  logic             wb_e,
   input  logic [4:0]       wb_a,
   input  logic [31:0]      wb_d,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [7:0]       tx_data,
   output logic             overflow,
   output logic [CNT_W-1:0] drop_count,
   output logic             drained
);
   trc_state_e         state_q;
   ser_state_e         ser_q;
   logic [CNT_W-1:0]   idx_q, drop_q;
   logic               gap_q, overflow_q, drained_q;
   logic [2:0]         byte_q;
   logic [REC_W-1:0]   sh_q, head;
   logic               f_full, f_empty;
   logic [$clog2(DEPTH):0] f_count;
   logic               want, cap, push, drop, pop, last;
   trace_rec_s         rec;

`ifdef TRACE_FILTER_EN
   assign want = (wb_e && wb_a != 5'd0) || done;
`else
   assign want = 1'b1;
`endif

   assign cap  = state_q == CAPTURE && trace_en && (ins_done || done) && want;
   // Fullness is judged on the registered count, so a same-cycle pop cannot rescue a full FIFO
   assign push = cap && !f_full;
   assign drop = cap && f_full;
   assign last = byte_q == 3'(REC_BYTES - 1);
   // Popping on the last accepted byte keeps records back-to-back with no idle cycle
   assign pop  = !f_empty && (ser_q == SER_IDLE || (tx_ready && last));

   always_comb begin
      rec            = '0;
      rec.retire_idx = idx_q[15:0];
      rec.is_final   = done;
      rec.ovf_gap    = gap_q;
      rec.wb_e       = wb_e;
      rec.wb_a       = wb_a;
      rec.wb_d       = wb_d;
   end

   trace_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (rec),
      .rdata_o (head),
      .full_o  (f_full),
      .empty_o (f_empty),
      .count_o (f_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= CAPTURE;
         ser_q      <= SER_IDLE;
         idx_q      <= '0;
         drop_q     <= '0;
         gap_q      <= 1'b0;
         overflow_q <= 1'b0;
         drained_q  <= 1'b0;
         byte_q     <= '0;
         sh_q       <= '0;
      end else begin
         if (state_q == CAPTURE) begin
            if (ins_done) idx_q <= idx_q + 1'b1;
            if (done) state_q <= STOPPED;
         end
         if (drop) begin
            overflow_q <= 1'b1;
            gap_q      <= 1'b1;
            if (~&drop_q) drop_q <= drop_q + 1'b1;
         end else if (push) begin
            gap_q <= 1'b0;
         end
         drained_q <= state_q == STOPPED && f_count == '0 && ser_q == SER_IDLE;
         if (pop) begin
            sh_q   <= head;
            byte_q <= '0;
            ser_q  <= SER_SEND;
         end else if (ser_q == SER_SEND && tx_ready) begin
            sh_q   <= sh_q << 8;
            byte_q <= byte_q + 3'd1;
            if (last) ser_q <= SER_IDLE;
         end
      end
   end

   assign tx_valid   = ser_q == SER_SEND;
   assign tx_data    = sh_q[REC_W-1 -: 8];
   assign overflow   = overflow_q;
   assign drop_count = drop_q;
   assign drained    = drained_q;
endmodule
